// File: rtl/c1541_sd_pkg.sv
// Shared types and constants for the C1541/2031 SD image-channel arbiter.
package c1541_sd_pkg;

   typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} sd_arb_state_t;

   localparam int MAX_DRIVES = 4;
   localparam int GRANT_W    = 2;

endpackage

// File: rtl/c1541_rr_pick.sv
// Combinational round-robin picker: first set request searching upward
// from last+1, wrapping modulo NDR.
module c1541_rr_pick
   import c1541_sd_pkg::*;
#(
   parameter int NDR = 2
) (
   input  logic [NDR-1:0]     req,
   input  logic [GRANT_W-1:0] last,
   output logic               valid,
   output logic [GRANT_W-1:0] idx
);

   logic [MAX_DRIVES-1:0] req_pad;
   logic [GRANT_W-1:0]    cand [NDR];
   logic [NDR-1:0]        hit;

   assign req_pad = MAX_DRIVES'(req);

   // cand[k] is the drive visited k+1 steps after the last winner.
   genvar gi;
   generate
      for (gi = 0; gi < NDR; gi++) begin : g_cand
         assign cand[gi] = GRANT_W'((int'(last) + gi + 1) % NDR);
         assign hit[gi]  = req_pad[cand[gi]];
      end
   endgenerate

   always_comb begin
      valid = |req;
      idx   = '0;
      for (int k = NDR - 1; k >= 0; k--) begin
         if (hit[k]) idx = cand[k];
      end
   end

endmodule

// File: rtl/c1541_sd_arbiter.sv
// Round-robin arbiter multiplexing per-drive SD block requests onto the
// single host SD image channel; one whole request/ack transaction per grant.
module c1541_sd_arbiter
   import c1541_sd_pkg::*;
#(
   parameter int NDR = 2
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic [31:0]       drv_lba     [NDR],
   input  logic [5:0]        drv_blk_cnt [NDR],
   input  logic [NDR-1:0]    drv_rd,
   input  logic [NDR-1:0]    drv_wr,
   output logic [NDR-1:0]    drv_ack,
   input  logic [7:0]        drv_buff_din [NDR],
   output logic [31:0]       sd_lba,
   output logic [5:0]        sd_blk_cnt,
   output logic              sd_rd,
   output logic              sd_wr,
   input  logic              sd_ack,
   output logic [7:0]        sd_buff_din,
   output logic [1:0]        grant,
   output logic              busy
);

   localparam int N = NDR - 1;

   sd_arb_state_t       state_reg, state_next;
   logic [GRANT_W-1:0]  grant_reg, grant_next;
   logic [GRANT_W-1:0]  last_reg, last_next;
   logic                sd_rd_reg, sd_rd_next;
   logic                sd_wr_reg, sd_wr_next;
   logic [31:0]         lba_reg, lba_next;
   logic [5:0]          blk_reg, blk_next;

   logic [31:0]           lba_pad [MAX_DRIVES];
   logic [5:0]            blk_pad [MAX_DRIVES];
   logic [7:0]            din_pad [MAX_DRIVES];
   logic [MAX_DRIVES-1:0] rd_pad, wr_pad;
   logic                  pick_valid;
   logic [GRANT_W-1:0]    pick_idx;
   logic                  ack_window;

   assign rd_pad = MAX_DRIVES'(drv_rd);
   assign wr_pad = MAX_DRIVES'(drv_wr);

   // Widen the per-drive arrays to MAX_DRIVES so a 2-bit index is always legal.
   genvar gi;
   generate
      for (gi = 0; gi < MAX_DRIVES; gi++) begin : g_pad
         if (gi < NDR) begin : g_real
            assign lba_pad[gi] = drv_lba[gi];
            assign blk_pad[gi] = drv_blk_cnt[gi];
            assign din_pad[gi] = drv_buff_din[gi];
         end else begin : g_none
            assign lba_pad[gi] = '0;
            assign blk_pad[gi] = '0;
            assign din_pad[gi] = '0;
         end
      end
   endgenerate

   c1541_rr_pick #(.NDR(NDR)) u_pick (
      .req   (drv_rd | drv_wr),
      .last  (last_reg),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_reg <= IDLE;
         grant_reg <= '0;
         last_reg  <= GRANT_W'(N);
         sd_rd_reg <= 1'b0;
         sd_wr_reg <= 1'b0;
         lba_reg   <= '0;
         blk_reg   <= '0;
      end else begin
         state_reg <= state_next;
         grant_reg <= grant_next;
         last_reg  <= last_next;
         sd_rd_reg <= sd_rd_next;
         sd_wr_reg <= sd_wr_next;
         lba_reg   <= lba_next;
         blk_reg   <= blk_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      grant_next = grant_reg;
      last_next  = last_reg;
      sd_rd_next = sd_rd_reg;
      sd_wr_next = sd_wr_reg;
      lba_next   = lba_reg;
      blk_next   = blk_reg;
      case (state_reg)
         IDLE: begin
            if (pick_valid) begin
               grant_next = pick_idx;
               lba_next   = lba_pad[pick_idx];
               blk_next   = blk_pad[pick_idx];
               sd_rd_next = rd_pad[pick_idx];
               sd_wr_next = wr_pad[pick_idx] & ~rd_pad[pick_idx];
               state_next = REQ;
            end
         end
         REQ: begin
            if (sd_ack) begin
               sd_rd_next = 1'b0;
               sd_wr_next = 1'b0;
               state_next = XFER;
            end else if (!(rd_pad[grant_reg] | wr_pad[grant_reg])) begin
               sd_rd_next = 1'b0;
               sd_wr_next = 1'b0;
               last_next  = grant_reg;
               state_next = IDLE;
            end
         end
         XFER: begin
            if (!sd_ack) begin
               last_next  = grant_reg;
               state_next = GAP;
            end
         end
         GAP: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Ack is combinational so the first buffer write beat reaches the drive.
   assign ack_window = (state_reg == REQ) || (state_reg == XFER);

   generate
      for (gi = 0; gi < NDR; gi++) begin : g_ack
         assign drv_ack[gi] = sd_ack & ack_window & (grant_reg == GRANT_W'(gi));
      end
   endgenerate

   assign sd_buff_din = din_pad[grant_reg];
   assign sd_lba      = lba_reg;
   assign sd_blk_cnt  = blk_reg;
   assign sd_rd       = sd_rd_reg;
   assign sd_wr       = sd_wr_reg;
   assign grant       = grant_reg;
   assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_c1541_sd_arbiter.sv
// Scoreboard bench for c1541_sd_arbiter with four drives and a simple host model.
module tb_c1541_sd_arbiter;

   localparam int NDR = 4;

   logic           clk_sys = 1'b0;
   logic           reset;
   logic [31:0]    drv_lba      [NDR];
   logic [5:0]     drv_blk_cnt  [NDR];
   logic [NDR-1:0] drv_rd, drv_wr, drv_ack;
   logic [7:0]     drv_buff_din [NDR];
   logic [31:0]    sd_lba;
   logic [5:0]     sd_blk_cnt;
   logic           sd_rd, sd_wr, sd_ack;
   logic [7:0]     sd_buff_din;
   logic [1:0]     grant;
   logic           busy;

   typedef struct {
      logic [1:0]  g;
      logic [31:0] lba;
      logic [5:0]  blk;
      logic        rd;
      logic        wr;
   } exp_t;

   exp_t exp_q[$];
   int   checks    = 0;
   int   errors    = 0;
   int   idle_run  = 100;
   int   last_gap  = 100;
   bit   was_req   = 1'b0;

   always #5 clk_sys = ~clk_sys;

   c1541_sd_arbiter #(.NDR(NDR)) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .drv_lba      (drv_lba),
      .drv_blk_cnt  (drv_blk_cnt),
      .drv_rd       (drv_rd),
      .drv_wr       (drv_wr),
      .drv_ack      (drv_ack),
      .drv_buff_din (drv_buff_din),
      .sd_lba       (sd_lba),
      .sd_blk_cnt   (sd_blk_cnt),
      .sd_rd        (sd_rd),
      .sd_wr        (sd_wr),
      .sd_ack       (sd_ack),
      .sd_buff_din  (sd_buff_din),
      .grant        (grant),
      .busy         (busy)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Advance to the next falling edge and track idle cycles between host requests.
   task automatic tick();
      @(negedge clk_sys);
      if (sd_rd | sd_wr) begin
         if (!was_req) last_gap = idle_run;
         idle_run = 0;
         was_req  = 1'b1;
      end else begin
         idle_run++;
         was_req = 1'b0;
      end
   endtask

   task automatic push_exp(input int g, input logic rd, input logic wr);
      exp_t e;
      e.g   = 2'(g);
      e.lba = drv_lba[g];
      e.blk = drv_blk_cnt[g];
      e.rd  = rd;
      e.wr  = wr;
      exp_q.push_back(e);
   endtask

   task automatic wait_req(output exp_t e, output int waited);
      waited = 0;
      do begin
         tick();
         waited++;
      end while (!(sd_rd | sd_wr) && waited < 20);
      check("req_seen", 32'(sd_rd | sd_wr), 32'd1);
      check("sb_depth", exp_q.size(), 32'd1);
      e = exp_q.pop_front();
      check("grant", grant, e.g);
      check("sd_lba", sd_lba, e.lba);
      check("sd_blk_cnt", sd_blk_cnt, e.blk);
      check("sd_rd", sd_rd, e.rd);
      check("sd_wr", sd_wr, e.wr);
      check("busy", busy, 1);
      $display("txn: grant=%0d lba=%h blk=%0d rd=%0d wr=%0d after %0d cycles",
               grant, sd_lba, sd_blk_cnt, sd_rd, sd_wr, waited);
   endtask

   task automatic serve(input int n_ack, input bit drop, output int waited);
      exp_t e;
      wait_req(e, waited);
      sd_ack = 1'b1;
      for (int k = 0; k < n_ack; k++) begin
         #1;
         check("drv_ack", drv_ack, 32'(4'b0001 << e.g));
         if (e.wr) check("sd_buff_din", sd_buff_din, drv_buff_din[e.g]);
         tick();
         if (k == 0) begin
            check("req_clr", 32'(sd_rd | sd_wr), 32'd0);
            if (drop) begin
               drv_rd[e.g] = 1'b0;
               drv_wr[e.g] = 1'b0;
            end
         end
      end
      sd_ack = 1'b0;
      #1;
      check("ack_off", drv_ack, 32'd0);
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      sd_ack = 1'b0;
      drv_rd = '0;
      drv_wr = '0;
      tick();
      tick();
      reset    = 1'b0;
      idle_run = 100;
      exp_q.delete();
   endtask

   initial begin
      exp_t e;
      int   w;
      for (int i = 0; i < NDR; i++) begin
         drv_lba[i]      = 32'h1000 * (i + 1) + 32'h11;
         drv_blk_cnt[i]  = 6'(i + 3);
         drv_buff_din[i] = 8'(8'h30 + i);
      end
      drv_lba[1] = 32'h123;

      // Reset state
      do_reset();
      check("rst_sd_rd", sd_rd, 0);
      check("rst_sd_wr", sd_wr, 0);
      check("rst_busy", busy, 0);
      check("rst_grant", grant, 0);
      check("rst_lba", sd_lba, 0);
      check("rst_blk", sd_blk_cnt, 0);
      check("rst_ack", drv_ack, 0);

      // Single read from drive 1, five ack cycles
      drv_rd[1] = 1'b1;
      push_exp(1, 1, 0);
      serve(5, 1, w);
      check("latency", w, 1);

      // Simultaneous requests: grants 0, 1, 3 with >=3 idle cycles between
      do_reset();
      drv_rd = 4'b1011;
      push_exp(0, 1, 0);
      serve(2, 1, w);
      push_exp(1, 1, 0);
      serve(2, 1, w);
      check("gap_01", 32'(last_gap >= 3), 1);
      push_exp(3, 1, 0);
      serve(2, 1, w);
      check("gap_13", 32'(last_gap >= 3), 1);

      // Fairness: drive 0 re-requests immediately, drive 2 held high
      do_reset();
      drv_rd = 4'b0101;
      for (int r = 0; r < 2; r++) begin
         push_exp(0, 1, 0);
         serve(1, 1, w);
         drv_rd[0] = 1'b1;
         push_exp(2, 1, 0);
         serve(1, 0, w);
      end
      drv_rd = '0;

      // Write path, then read-wins when both are set
      do_reset();
      drv_buff_din[1] = 8'hA5;
      drv_wr[1] = 1'b1;
      push_exp(1, 0, 1);
      serve(3, 1, w);
      drv_rd[1] = 1'b1;
      drv_wr[1] = 1'b1;
      push_exp(1, 1, 0);
      serve(2, 1, w);

      // Abort in REQ, then a stray ack in IDLE
      do_reset();
      drv_rd[0] = 1'b1;
      push_exp(0, 1, 0);
      wait_req(e, w);
      drv_rd[0] = 1'b0;
      tick();
      check("abort_rd", sd_rd, 0);
      check("abort_busy", busy, 0);
      sd_ack = 1'b1;
      #1;
      check("stray_ack", drv_ack, 0);
      tick();
      check("stray_ack2", drv_ack, 0);
      check("stray_busy", busy, 0);
      sd_ack = 1'b0;

      // Reset mid-XFER with ack still high
      do_reset();
      drv_rd = 4'b0010;
      push_exp(1, 1, 0);
      wait_req(e, w);
      sd_ack = 1'b1;
      tick();
      reset  = 1'b1;
      drv_rd = 4'b0011;
      tick();
      #1;
      check("mid_rst_ack", drv_ack, 0);
      check("mid_rst_rd", sd_rd, 0);
      check("mid_rst_wr", sd_wr, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_grant", grant, 0);
      reset  = 1'b0;
      sd_ack = 1'b0;
      exp_q.delete();
      push_exp(0, 1, 0);
      serve(2, 1, w);
      push_exp(1, 1, 0);
      serve(2, 1, w);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
